// File: rtl/sprite_scheduler.sv
// sprite_scheduler: double-buffered sprite table walker that feeds a blitter.
// A staging table is written at any time through i_tbl_we. Each accepted
// frame_start copies staging into the active table. The active table is then
// walked from entry 0 upward, so higher entries are drawn on top.
//
// Optional shadow pass: define SPRITE_SCHEDULER_SHADOW_EN. With it, entries
// flagged as shadow are issued twice. The first pass is offset by SHADOW_OFS
// in x and y, uses address 0 and has o_is_shadow=1. The second is the normal pass.
//
// Blitter handshake: o_new_sprite is a one-cycle request. The job fields
// (o_is_shadow, o_sprite_*) stay stable from that cycle until the cycle after
// the one-cycle i_wrote_sprite completion. The next request comes at least
// two cycles after i_wrote_sprite. i_wrote_sprite is ignored unless a job is
// outstanding.
module sprite_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int SHADOW_OFS  = 4,
  localparam int IW = $clog2(NUM_SPRITES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame_start,
  input  logic          i_tbl_we,
  input  logic [IW-1:0] i_tbl_addr,
  input  logic          i_tbl_en,
  input  logic          i_tbl_shadow,
  input  logic [9:0]    i_tbl_x,
  input  logic [9:0]    i_tbl_y,
  input  logic [9:0]    i_tbl_dimx,
  input  logic [9:0]    i_tbl_dimy,
  input  logic [24:0]   i_tbl_address,
  output logic          o_new_sprite,
  output logic          o_is_shadow,
  output logic [9:0]    o_sprite_x_pos,
  output logic [9:0]    o_sprite_y_pos,
  output logic [9:0]    o_sprite_dimx,
  output logic [9:0]    o_sprite_dimy,
  output logic [24:0]   o_sprite_address,
  input  logic          i_wrote_sprite,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_overrun,
  output logic [2:0]    o_dbg_state
);

  typedef struct packed {
    logic        en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  dimx;
    logic [9:0]  dimy;
    logic [24:0] addr;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
`ifdef SPRITE_SCHEDULER_SHADOW_EN
    ,
    S_ISSUE_SHD = 3'd5,
    S_WAIT_SHD  = 3'd6
`endif
  } state_t;

  localparam logic [IW-1:0] L_LAST    = IW'(NUM_SPRITES - 1);
  localparam logic [9:0]    L_SHD_OFS = 10'(SHADOW_OFS);

  entry_t        r_stg [NUM_SPRITES];
  entry_t        r_act [NUM_SPRITES];
  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_new_sprite;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    r_dimx;
  logic [9:0]    r_dimy;
  logic [24:0]   r_addr;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_overrun;

  entry_t        w_wr_entry;
  entry_t        w_cur;
  logic          w_accept;
  logic          w_skip;
  logic          w_last;

  assign w_wr_entry = '{en: i_tbl_en, x: i_tbl_x, y: i_tbl_y, dimx: i_tbl_dimx,
                        dimy: i_tbl_dimy, addr: i_tbl_address};
  assign w_accept   = i_frame_start && (r_state == S_IDLE);
  assign w_cur      = r_act[r_idx];
  // Zero-size entries are skipped: they would hang the blitter's modulo counter.
  assign w_skip     = !w_cur.en || (w_cur.dimx == 10'd0) || (w_cur.dimy == 10'd0);
  assign w_last     = (r_idx == L_LAST);

`ifdef SPRITE_SCHEDULER_SHADOW_EN
  logic r_stg_shd [NUM_SPRITES];
  logic r_act_shd [NUM_SPRITES];
  logic r_is_shadow;

  // Shadow flags travel with the tables: staged on write, copied on frame accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_stg_shd[i] <= 1'b0;
        r_act_shd[i] <= 1'b0;
      end
    end else begin
      if (i_tbl_we) r_stg_shd[i_tbl_addr] <= i_tbl_shadow;
      if (w_accept) r_act_shd <= r_stg_shd;
    end
  end

  assign o_is_shadow = r_is_shadow;
`else
  logic [10:0] w_unused_shadow;
  assign w_unused_shadow = {i_tbl_shadow, L_SHD_OFS};
  assign o_is_shadow     = 1'b0;
`endif

  // Staging writes land in any state. The active copy on the accept edge reads
  // the pre-write staging contents, so a same-cycle write shows up next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_stg[i] <= '0;
        r_act[i] <= '0;
      end
    end else begin
      if (i_tbl_we) r_stg[i_tbl_addr] <= w_wr_entry;
      if (w_accept) r_act <= r_stg;
    end
  end

  // Frame walker FSM with registered request, job fields and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_new_sprite <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_dimx       <= '0;
      r_dimy       <= '0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SPRITE_SCHEDULER_SHADOW_EN
      r_is_shadow  <= 1'b0;
`endif
    end else begin
      r_new_sprite <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= i_frame_start && r_busy;
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_state <= S_SCAN;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (w_skip) begin
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx + IW'(1);
          end else begin
`ifdef SPRITE_SCHEDULER_SHADOW_EN
            r_state <= r_act_shd[r_idx] ? S_ISSUE_SHD : S_ISSUE;
`else
            r_state <= S_ISSUE;
`endif
          end
        end
`ifdef SPRITE_SCHEDULER_SHADOW_EN
        S_ISSUE_SHD: begin
          r_new_sprite <= 1'b1;
          r_is_shadow  <= 1'b1;
          r_x          <= w_cur.x + L_SHD_OFS;
          r_y          <= w_cur.y + L_SHD_OFS;
          r_dimx       <= w_cur.dimx;
          r_dimy       <= w_cur.dimy;
          r_addr       <= '0;
          r_state      <= S_WAIT_SHD;
        end
        S_WAIT_SHD: begin
          if (i_wrote_sprite) r_state <= S_ISSUE;
        end
`endif
        S_ISSUE: begin
          r_new_sprite <= 1'b1;
`ifdef SPRITE_SCHEDULER_SHADOW_EN
          r_is_shadow  <= 1'b0;
`endif
          r_x          <= w_cur.x;
          r_y          <= w_cur.y;
          r_dimx       <= w_cur.dimx;
          r_dimy       <= w_cur.dimy;
          r_addr       <= w_cur.addr;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (i_wrote_sprite) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_new_sprite     = r_new_sprite;
  assign o_sprite_x_pos   = r_x;
  assign o_sprite_y_pos   = r_y;
  assign o_sprite_dimx    = r_dimx;
  assign o_sprite_dimy    = r_dimy;
  assign o_sprite_address = r_addr;
  assign o_busy           = r_busy;
  assign o_frame_done     = r_frame_done;
  assign o_overrun        = r_overrun;
  assign o_dbg_state      = r_state;

endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 Parameter NUM_SPRITES, default 8: sprite table depth; a power of two, 2..16.
REQ-002 Parameter SHADOW_OFS, default 4: shadow displacement in pixels, applied to both x and y.
REQ-003 Clk  in  1  single clock; all logic on the rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 frame_start  in  1  one-cycle pulse that starts the draw of one frame.
REQ-006 tbl_we  in  1  staging-table write strobe.
REQ-007 tbl_addr  in  log2(NUM_SPRITES)  staging entry index.
REQ-008 tbl_en, tbl_shadow  in  1 each  entry enable; entry casts a shadow.
REQ-009 tbl_x, tbl_y, tbl_dimx, tbl_dimy  in  10 each  screen position and size in pixels.
REQ-010 tbl_address  in  25  SDRAM word address of the sprite image.
REQ-011 new_sprite  out  1  one-cycle request to the blitter.
REQ-012 is_shadow  out  1  current request is a shadow pass.
REQ-013 sprite_x_pos, sprite_y_pos, sprite_dimx, sprite_dimy  out  10 each; sprite_address  out  25  current job fields.
REQ-014 wrote_sprite  in  1  one-cycle completion pulse from the blitter.
REQ-015 busy  out  1; frame_done  out  1 (pulse); overrun  out  1 (pulse).

Function
REQ-016 The block SHALL hold two tables: staging (written by tbl_we) and active (used for drawing).
REQ-017 tbl_we SHALL write every field of the addressed staging entry at the clock edge, in any state.
REQ-018 When frame_start is accepted in IDLE, the block SHALL copy staging to active on the same edge, set busy, and clear the index to 0.
REQ-019 If tbl_we and frame_start are accepted in the same cycle, the block SHALL copy the pre-write staging contents; the new data SHALL take effect at the next frame.
REQ-020 States: IDLE, SCAN, ISSUE_SHD, WAIT_SHD, ISSUE, WAIT, DONE.
REQ-021 In SCAN, an entry with tbl_en=0, dimx=0 or dimy=0 SHALL be skipped in one cycle; dimensions of zero would hang the blitter's modulo counter.
REQ-022 SCAN SHALL go to ISSUE_SHD if the entry's shadow flag is set and the shadow feature is compiled in; otherwise it SHALL go to ISSUE.
REQ-023 ISSUE and ISSUE_SHD SHALL assert new_sprite for exactly one cycle, then go to WAIT or WAIT_SHD respectively.
REQ-024 All job outputs SHALL stay stable from the new_sprite cycle until the cycle after wrote_sprite.
REQ-025 On wrote_sprite, WAIT_SHD SHALL go to ISSUE for the same entry.
REQ-026 On wrote_sprite, WAIT SHALL increment the index and go to SCAN, or go to DONE after the last entry.
REQ-027 The next new_sprite SHALL come no earlier than 2 cycles after wrote_sprite, so that the blitter is back in its WAIT state.
REQ-028 wrote_sprite in any state other than WAIT or WAIT_SHD SHALL be ignored.
REQ-029 DONE SHALL pulse frame_done for one cycle, clear busy, and go to IDLE.
REQ-030 Draw order SHALL be entry 0 up to entry NUM_SPRITES-1, so higher entries are drawn on top.
REQ-031 frame_start while busy SHALL be ignored and SHALL pulse overrun for one cycle.
REQ-032 When is_shadow=1, sprite_address SHALL be 0 and the dimensions SHALL be those of the entry.
REQ-033 A frame with no drawable entries SHALL assert frame_done exactly NUM_SPRITES+2 cycles after frame_start.

Reset
REQ-034 Reset_n low SHALL asynchronously force state IDLE and clear both tables, the index, and all outputs to 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.
REQ-036 After reset is released, the first frame_start SHALL be accepted normally.

Configuration
REQ-037 Macro SPRITE_SCHEDULER_SHADOW_EN defined: shadow entries SHALL issue a shadow pass before the normal pass.
REQ-038 The shadow pass SHALL use x+SHADOW_OFS and y+SHADOW_OFS, each wrapping modulo 1024.
REQ-039 Macro SPRITE_SCHEDULER_SHADOW_EN undefined: tbl_shadow SHALL be ignored, is_shadow SHALL be tied to 0, and the shadow states SHALL be absent.

Verification
REQ-040 Scenario: write entry 0 (x=100, y=50, dim 16x16, address 0x1000, enabled); frame_start; wrote_sprite 20 cycles after new_sprite -> one new_sprite with those fields, then frame_done, busy=0.
REQ-041 Scenario (macro on): entry 2 with shadow, x=10, y=1022 -> first new_sprite has is_shadow=1, x=14, y=2; second has is_shadow=0, x=10, y=1022.
REQ-042 Scenario: entries 1 and 3 enabled, entry 5 enabled with dimx=0 -> exactly two new_sprite pulses, for entries 1 then 3.
REQ-043 Scenario: frame_start while busy -> overrun pulse, no restart; tbl_we to entry 0 mid-frame -> the current frame is unchanged and the next frame uses the new data.
REQ-044 Scenario: Reset_n low during WAIT -> all outputs 0 immediately; a later stray wrote_sprite is ignored; the next frame_start draws normally.
REQ-045 Scenario: all entries disabled, NUM_SPRITES=8 -> frame_done 10 cycles after frame_start and no new_sprite pulse.
